// File: rtl/bin2bcd_pkg.sv
// ---------------------------------------------------------------------------
// bin2bcd_pkg
// Shared types, constants and elaboration-time helpers for the sequential
// double-dabble binary-to-BCD converter.
//   state_t      : converter FSM states
//   DIGIT_W      : width of one BCD digit
//   cnt_width()  : bit counter width for a given binary width
//   min_digits() : decimal digits needed to hold 2**bin_w - 1
// ---------------------------------------------------------------------------
package bin2bcd_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int DIGIT_W = 4;

   // The counter is loaded with BIN_W itself, so it needs room for that value.
   function automatic int cnt_width(input int bin_w);
      return $clog2(bin_w + 1);
   endfunction

   // Number of decimal digits of the largest BIN_W-bit value; equal to
   // ceil(bin_w*log10(2)) because bin_w*log10(2) is never an integer.
   function automatic int min_digits(input int bin_w);
      longint unsigned v;
      int              d;
      v = (64'd1 << bin_w) - 64'd1;
      d = 1;
      while (v >= 64'd10) begin
         v = v / 64'd10;
         d++;
      end
      return d;
   endfunction

endpackage : bin2bcd_pkg

// File: rtl/bcd_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble correction cell: a digit of 5 or more gets 3
// added so that the following left shift carries correctly into the next
// decimal digit.
//   i_digit : working BCD digit before correction
//   o_digit : corrected digit (4-bit arithmetic, never overflows for 0..9)
// ---------------------------------------------------------------------------
module bcd_add3
   import bin2bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] i_digit,
   output logic [DIGIT_W-1:0] o_digit
);

   assign o_digit = (i_digit >= DIGIT_W'(5)) ? i_digit + DIGIT_W'(3) : i_digit;

endmodule : bcd_add3

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter: one correction-and-shift step per
// clock, BIN_W clocks from an accepted start to the done pulse.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : conversion request, accepted only in IDLE
//   bin    : unsigned binary value, captured on the accepting edge
//   busy   : high while a conversion is in progress
//   done   : one-cycle pulse, bcd valid and updated in the same cycle
//   bcd    : packed BCD result, digit 0 (units) in bits [3:0]
// ---------------------------------------------------------------------------
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [BIN_W-1:0]          bin,
   output logic                      busy,
   output logic                      done,
   output logic [DIGIT_W*DIGITS-1:0] bcd
);

   localparam int CNT_W = cnt_width(BIN_W);
   localparam int BCD_W = DIGIT_W * DIGITS;

   if (BIN_W < 4 || BIN_W > 32) begin : g_bad_bin_w
      $fatal(1, "bin2bcd_seq: BIN_W=%0d outside 4..32", BIN_W);
   end
   if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
      $fatal(1, "bin2bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
   end

   state_t             r_state;
   state_t             w_next_state;
   logic               w_load;
   logic               w_step;
   logic               w_last;
   logic [CNT_W-1:0]   r_cnt;
   logic [BIN_W-1:0]   r_shift;
   logic [BCD_W-1:0]   r_work;
   logic [BCD_W-1:0]   w_corr;
   logic [BCD_W-1:0]   w_work_next;
   logic [BCD_W-1:0]   r_bcd;
   logic               r_done;

   // Correction is derived from the current digits, then the shift follows.
   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .i_digit (r_work[g*DIGIT_W +: DIGIT_W]),
         .o_digit (w_corr[g*DIGIT_W +: DIGIT_W])
      );
   end

   // {digits, shift reg} << 1: the MSB of the binary word enters digit 0.
   assign w_work_next = {w_corr[BCD_W-2:0], r_shift[BIN_W-1]};

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: every signal gets a default before the case so that no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_step       = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load       = 1'b1;
               w_next_state = SHIFT;
            end
         end
         SHIFT: begin
            w_step = 1'b1;
            if (r_cnt == CNT_W'(1)) begin
               w_last       = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_shift <= '0;
         r_work  <= '0;
         r_bcd   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_load) begin
            r_shift <= bin;
            r_work  <= '0;
            r_cnt   <= CNT_W'(BIN_W);
         end else if (w_step) begin
            r_shift <= {r_shift[BIN_W-2:0], 1'b0};
            r_work  <= w_work_next;
            r_cnt   <= r_cnt - CNT_W'(1);
         end
         // Only the final step reaches the output, so partial results stay hidden.
         if (w_last) begin
            r_bcd <= w_work_next;
         end
      end
   end

   assign busy = (r_state == SHIFT);
   assign done = r_done;
   assign bcd  = r_bcd;

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
// Directed bench for bin2bcd_seq at default parameters (16-bit in, 5 digits).
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bin2bcd_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] bin;
   logic        busy;
   logic        done;
   logic [19:0] bcd;

   int n_cmp = 0;
   int n_err = 0;

   bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Assert start for one edge. Returns at the falling edge right after the
   // accepting edge E0.
   task automatic launch(input logic [15:0] v);
      @(negedge clk);
      start = 1'b1;
      bin   = v;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at the falling edge after E0 (offset 0). Waits for done and reports
   // the edge offset of done, busy cycle count and overlap. Optionally pulses
   // start with a different bin at offset poke_at.
   task automatic wait_result(input int poke_at, output logic [19:0] res,
                              output int lat, output int busy_cycles,
                              output bit overlap, output bit timeout);
      lat = 0; busy_cycles = 0; overlap = 1'b0; timeout = 1'b1; res = 'x;
      for (int k = 0; k < 40; k++) begin
         if (done && busy) overlap = 1'b1;
         if (done) begin
            res     = bcd;
            timeout = 1'b0;
            break;
         end
         if (busy) busy_cycles++;
         if (k == poke_at) begin
            start = 1'b1;
            bin   = 16'h1234;
         end else if (k == poke_at + 1) begin
            start = 1'b0;
            bin   = 16'hFFFF;
         end
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; bin = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, done, bcd} !== 22'd0) begin
         n_err++;
         $display("FAIL reset_state: busy=%b done=%b bcd=%h, required 0 0 00000", busy, done, bcd);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({busy, done, bcd} !== 22'd0) begin
         n_err++;
         $display("FAIL idle_after_reset: busy=%b done=%b bcd=%h, required 0 0 00000", busy, done, bcd);
      end
   endtask

   task automatic test_zero();
      logic [19:0] res; int lat, bc; bit ov, to;
      launch(16'd0);
      wait_result(-5, res, lat, bc, ov, to);
      n_cmp++;
      if (to || res !== 20'h00000) begin
         n_err++;
         $display("FAIL zero_result: bcd=%h timeout=%b, required 00000", res, to);
      end
      n_cmp++;
      if (lat !== 16 || bc !== 16 || ov) begin
         n_err++;
         $display("FAIL zero_timing: latency=%0d busy_cycles=%0d overlap=%b, required 16 16 0", lat, bc, ov);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || bcd !== 20'h00000) begin
         n_err++;
         $display("FAIL zero_done_pulse: done=%b busy=%b bcd=%h, required 0 0 00000", done, busy, bcd);
      end
   endtask

   task automatic test_max();
      logic [19:0] res; int lat, bc; bit ov, to;
      launch(16'd65535);
      wait_result(-5, res, lat, bc, ov, to);
      n_cmp++;
      if (to || res !== 20'h65535 || lat !== 16 || ov) begin
         n_err++;
         $display("FAIL max_value: bcd=%h latency=%0d overlap=%b, required 65535 16 0", res, lat, ov);
      end
      n_cmp++;
      if (bcd[3:0] !== 4'd5) begin
         n_err++;
         $display("FAIL max_units_digit: digit0=%0d, required 5", bcd[3:0]);
      end
      // Result must hold across idle cycles.
      repeat (5) @(negedge clk);
      n_cmp++;
      if (bcd !== 20'h65535 || done !== 1'b0) begin
         n_err++;
         $display("FAIL max_hold: bcd=%h done=%b, required 65535 0", bcd, done);
      end
   endtask

   task automatic test_vectors();
      logic [15:0] vin [12] = '{16'd1, 16'd5, 16'd8, 16'd10, 16'd99, 16'd100,
                                16'd255, 16'd1000, 16'd4096, 16'd32768,
                                16'd59999, 16'd65534};
      logic [19:0] vexp [12] = '{20'h00001, 20'h00005, 20'h00008, 20'h00010,
                                 20'h00099, 20'h00100, 20'h00255, 20'h01000,
                                 20'h04096, 20'h32768, 20'h59999, 20'h65534};
      logic [19:0] res; int lat, bc; bit ov, to;
      for (int i = 0; i < 12; i++) begin
         launch(vin[i]);
         wait_result(-5, res, lat, bc, ov, to);
         n_cmp++;
         if (to || res !== vexp[i] || lat !== 16 || bc !== 16 || ov) begin
            n_err++;
            $display("FAIL vector_%0d: bin=%0d bcd=%h latency=%0d busy=%0d overlap=%b, required %h 16 16 0",
                     i, vin[i], res, lat, bc, ov, vexp[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [19:0] res; int lat, bc; bit ov, to;
      launch(16'd12345);
      wait_result(-5, res, lat, bc, ov, to);
      n_cmp++;
      if (to || res !== 20'h12345) begin
         n_err++;
         $display("FAIL b2b_first: bcd=%h timeout=%b, required 12345", res, to);
      end
      // Hold start through the done cycle; it is accepted at the edge ending it.
      start = 1'b1;
      bin   = 16'd9;
      @(negedge clk);
      start = 1'b0;
      bin   = 16'd777;
      wait_result(-5, res, lat, bc, ov, to);
      n_cmp++;
      if (to || res !== 20'h00009) begin
         n_err++;
         $display("FAIL b2b_second: bcd=%h timeout=%b, required 00009", res, to);
      end
      // 16 non-done cycles separate the two done pulses.
      n_cmp++;
      if (lat !== 16 || bc !== 16 || ov) begin
         n_err++;
         $display("FAIL b2b_spacing: gap=%0d busy_cycles=%0d overlap=%b, required 16 16 0", lat, bc, ov);
      end
   endtask

   task automatic test_mid_start();
      logic [19:0] res; int lat, bc; bit ov, to; int extra;
      launch(16'd4660);
      wait_result(5, res, lat, bc, ov, to);
      n_cmp++;
      if (to || res !== 20'h04660 || lat !== 16 || ov) begin
         n_err++;
         $display("FAIL mid_start_result: bcd=%h latency=%0d overlap=%b, required 04660 16 0", res, lat, ov);
      end
      extra = 0;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      n_cmp++;
      if (extra !== 0 || bcd !== 20'h04660) begin
         n_err++;
         $display("FAIL mid_start_single_done: extra_activity=%0d bcd=%h, required 0 04660", extra, bcd);
      end
   endtask

   task automatic test_reset_mid();
      logic [19:0] res; int lat, bc; bit ov, to; int seen;
      launch(16'd999);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, bcd} !== 22'd0) begin
         n_err++;
         $display("FAIL reset_mid_outputs: busy=%b done=%b bcd=%h, required 0 0 00000", busy, done, bcd);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      n_cmp++;
      if (seen !== 0 || bcd !== 20'h00000) begin
         n_err++;
         $display("FAIL reset_mid_no_done: activity=%0d bcd=%h, required 0 00000", seen, bcd);
      end
      launch(16'd999);
      wait_result(-5, res, lat, bc, ov, to);
      n_cmp++;
      if (to || res !== 20'h00999 || lat !== 16 || ov) begin
         n_err++;
         $display("FAIL reset_mid_rerun: bcd=%h latency=%0d overlap=%b, required 00999 16 0", res, lat, ov);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      bin   = '0;
      test_reset();
      test_zero();
      test_max();
      test_vectors();
      test_back_to_back();
      test_mid_start();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_bin2bcd_seq
